ni_packetizer: RTL and testbench

//  Transmit side of the NI-to-router link: builds HEAD / body / TRAILER flit packets and drives the router's NI flit input.
//  - Host writes payload bytes into an internal byte FIFO, then issues a command giving destination and length.
//  - Block waits for the router's free, then streams HEAD {6'b101111,dest}, the payload bytes, and TRAILER 8'hFF.

---
 rtl/noc_pkg.sv | 32 +++
 rtl/ni_byte_fifo.sv | 62 ++++++
 rtl/ni_packetizer.sv | 148 ++++++++++++++
 tb/tb_ni_packetizer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NI/router link encodings, packetizer FSM states and command payload.
// Contents: flit width and reserved flit codes, head prefix, state enum,
// latched command struct and the payload-byte legality check.
package noc_pkg;

    localparam int unsigned FLIT_W = 8;
    localparam int unsigned DEST_W = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [5:0]        HEAD_PREFIX = 6'b101111;
    localparam logic [FLIT_W-1:0] TRAILER     = 8'hFF;
    localparam logic [FLIT_W-1:0] IDLE_FLIT   = 8'h00;
    localparam logic [FLIT_W-1:0] SUB_BYTE    = 8'hFE;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_FREE = 2'd1,
        S_BODY      = 2'd2,
        S_TRAIL     = 2'd3
    } pkt_state_e;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [CNT_W-1:0]  len;
    } pkt_cmd_t;

    // Payload bytes that would be mistaken for idle, trailer or a head flit.
    function automatic logic is_illegal_byte(input logic [FLIT_W-1:0] b);
        return (b == IDLE_FLIT) || (b == TRAILER) || (b[FLIT_W-1:2] == HEAD_PREFIX);
    endfunction

endpackage

// File: rtl/ni_byte_fifo.sv
// Payload byte FIFO for the NI packetizer.
// Ports: clk, rst (async active-low), push/wr_data (write side),
// pop/rd_data_c (first-word fall-through read, combinational data),
// full/empty (registered status flags).
module ni_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_n;
    logic [PW-1:0]    rd_ptr_n;
    logic             do_push;
    logic             do_pop;

    // Status is taken from the registered flags, so a push and pop in the
    // same cycle both proceed based on the state before either happens.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign wr_ptr_n  = wr_ptr + PW'(do_push);
    assign rd_ptr_n  = rd_ptr + PW'(do_pop);
    assign rd_data_c = mem[rd_ptr[AW-1:0]];

    // Pointers and flags; the extra pointer MSB separates full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            empty  <= (wr_ptr_n == rd_ptr_n);
        end
    end

    // Storage array carries no reset; contents are only read when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ni_packetizer.sv
// Transmit side of the NI-to-router link: frames queued payload bytes as
// HEAD / body / TRAILER flits onto the router's NI input.
// Ports: clk, rst (async active-low); wr_en/wr_data/full (payload FIFO);
// cmd_valid/cmd_ready/cmd_dest/cmd_len (packet request); free (router
// switch free); flit_out (8'h00 = no flit); busy, pkt_done, err_len,
// err_byte (status pulses). All outputs are registered.
module ni_packetizer
    import noc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_LEN    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [FLIT_W-1:0] wr_data,
    output logic              full,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DEST_W-1:0] cmd_dest,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              free,
    output logic [FLIT_W-1:0] flit_out,
    output logic              busy,
    output logic              pkt_done,
    output logic              err_len,
    output logic              err_byte
);

    pkt_state_e        state;
    pkt_state_e        state_n;
    pkt_cmd_t          cmd_q;
    pkt_cmd_t          cmd_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              free_q;
    logic [FLIT_W-1:0] flit_n;
    logic              pkt_done_n;
    logic              err_len_n;
    logic              err_byte_n;
    logic              len_ok;
    logic              pop;
    logic [FLIT_W-1:0] fifo_data;
    logic              fifo_empty;

    ni_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .wr_data   (wr_data),
        .pop       (pop),
        .rd_data_c (fifo_data),
        .full      (full),
        .empty     (fifo_empty)
    );

    assign len_ok = (cmd_len != '0) && (cmd_len <= CNT_W'(MAX_LEN));

    // State, command latch and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            cnt       <= '0;
            free_q    <= 1'b0;
            flit_out  <= IDLE_FLIT;
            pkt_done  <= 1'b0;
            err_len   <= 1'b0;
            err_byte  <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_n;
            cmd_q     <= cmd_n;
            cnt       <= cnt_n;
            // free is retimed through a flop and only tracked while waiting,
            // so a level left over from a previous packet is never reused.
            free_q    <= (state == S_WAIT_FREE) && free;
            flit_out  <= flit_n;
            pkt_done  <= pkt_done_n;
            err_len   <= err_len_n;
            err_byte  <= err_byte_n;
            busy      <= (state_n != S_IDLE);
            cmd_ready <= (state_n == S_IDLE);
        end
    end

    // Next-state, flit selection and byte sanitising.
    always_comb begin
        state_n    = state;
        cmd_n      = cmd_q;
        cnt_n      = cnt;
        flit_n     = IDLE_FLIT;
        pkt_done_n = 1'b0;
        err_len_n  = 1'b0;
        err_byte_n = 1'b0;
        pop        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (len_ok) begin
                        cmd_n.dest = cmd_dest;
                        cmd_n.len  = cmd_len;
                        state_n    = S_WAIT_FREE;
                    end else begin
                        err_len_n = 1'b1;
                    end
                end
            end
            S_WAIT_FREE: begin
                if (free_q) begin
                    flit_n  = {HEAD_PREFIX, cmd_q.dest};
                    cnt_n   = '0;
                    state_n = S_BODY;
                end
            end
            S_BODY: begin
                // An empty FIFO leaves an idle bubble; the router holds the route.
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cnt_n = cnt + CNT_W'(1);
                    if (is_illegal_byte(fifo_data)) begin
                        flit_n     = SUB_BYTE;
                        err_byte_n = 1'b1;
                    end else begin
                        flit_n = fifo_data;
                    end
                    if (cnt_n == cmd_q.len) begin
                        state_n = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                flit_n     = TRAILER;
                pkt_done_n = 1'b1;
                state_n    = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed self-checking bench for ni_packetizer.
module tb_ni_packetizer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest;
    logic [7:0] cmd_len;
    logic       free;
    logic [7:0] flit_out;
    logic       busy;
    logic       pkt_done;
    logic       err_len;
    logic       err_byte;

    int n_cmp;
    int n_err;

    ni_packetizer #(
        .FIFO_DEPTH (16),
        .MAX_LEN    (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dest  (cmd_dest),
        .cmd_len   (cmd_len),
        .free      (free),
        .flit_out  (flit_out),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .err_len   (err_len),
        .err_byte  (err_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flit_step(input string tag, input logic [7:0] exp);
        step();
        chk(tag, flit_out, exp);
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] d, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_dest  = d;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        cmd_valid = 1'b0;
        cmd_dest  = 2'd0;
        cmd_len   = 8'd0;
        free      = 1'b0;

        // Reset values
        #12;
        chk("rst_flit", flit_out, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_done", 8'(pkt_done), 8'h00);
        chk("rst_errlen", 8'(err_len), 8'h00);
        chk("rst_errbyte", 8'(err_byte), 8'h00);
        chk("rst_full", 8'(full), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_ready", 8'(cmd_ready), 8'h01);

        // Basic packet: HEAD two edges after acceptance, then contiguous body
        push(8'h11);
        push(8'h22);
        push(8'h33);
        free = 1'b1;
        send_cmd(2'd2, 8'd3);
        chk("b_busy", 8'(busy), 8'h01);
        chk("b_ready", 8'(cmd_ready), 8'h00);
        chk("b_wait0", flit_out, 8'h00);
        flit_step("b_wait1", 8'h00);
        flit_step("b_head", 8'hBE);
        flit_step("b_d0", 8'h11);
        flit_step("b_d1", 8'h22);
        flit_step("b_d2", 8'h33);
        chk("b_done_early", 8'(pkt_done), 8'h00);
        flit_step("b_trail", 8'hFF);
        chk("b_done", 8'(pkt_done), 8'h01);
        flit_step("b_gap", 8'h00);
        chk("b_done_clr", 8'(pkt_done), 8'h00);
        chk("b_idle_busy", 8'(busy), 8'h00);

        // Wait on free
        free = 1'b0;
        push(8'h5A);
        send_cmd(2'd1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            chk("w_hold_flit", flit_out, 8'h00);
            chk("w_hold_busy", 8'(busy), 8'h01);
            step();
        end
        free = 1'b1;
        flit_step("w_free_seen", 8'h00);
        flit_step("w_head", 8'hBD);
        flit_step("w_d0", 8'h5A);
        flit_step("w_trail", 8'hFF);
        chk("w_done", 8'(pkt_done), 8'h01);
        step();

        // Underrun: bubbles inside BODY, late bytes resume the packet
        push(8'h21);
        push(8'h32);
        send_cmd(2'd0, 8'd4);
        flit_step("u_wait", 8'h00);
        flit_step("u_head", 8'hBC);
        flit_step("u_d0", 8'h21);
        flit_step("u_d1", 8'h32);
        flit_step("u_bub0", 8'h00);
        flit_step("u_bub1", 8'h00);
        chk("u_bub_busy", 8'(busy), 8'h01);
        wr_en   = 1'b1;
        wr_data = 8'h43;
        flit_step("u_bub2", 8'h00);
        wr_data = 8'h54;
        flit_step("u_d2", 8'h43);
        wr_en = 1'b0;
        flit_step("u_d3", 8'h54);
        flit_step("u_trail", 8'hFF);
        chk("u_done", 8'(pkt_done), 8'h01);
        step();

        // Illegal payload bytes are substituted
        push(8'h00);
        push(8'hFF);
        push(8'hBE);
        push(8'h7A);
        send_cmd(2'd3, 8'd4);
        flit_step("i_wait", 8'h00);
        flit_step("i_head", 8'hBF);
        chk("i_head_noerr", 8'(err_byte), 8'h00);
        flit_step("i_d0", 8'hFE);
        chk("i_e0", 8'(err_byte), 8'h01);
        flit_step("i_d1", 8'hFE);
        chk("i_e1", 8'(err_byte), 8'h01);
        flit_step("i_d2", 8'hFE);
        chk("i_e2", 8'(err_byte), 8'h01);
        flit_step("i_d3", 8'h7A);
        chk("i_e3", 8'(err_byte), 8'h00);
        flit_step("i_trail", 8'hFF);
        chk("i_e_trail", 8'(err_byte), 8'h00);
        step();

        // Length errors leave the queued byte in place
        push(8'h66);
        send_cmd(2'd0, 8'd0);
        chk("l0_err", 8'(err_len), 8'h01);
        chk("l0_busy", 8'(busy), 8'h00);
        chk("l0_flit", flit_out, 8'h00);
        step();
        chk("l0_clr", 8'(err_len), 8'h00);
        send_cmd(2'd2, 8'd16);
        chk("l16_err", 8'(err_len), 8'h01);
        chk("l16_ready", 8'(cmd_ready), 8'h01);
        chk("l16_flit", flit_out, 8'h00);
        step();
        chk("l16_clr", 8'(err_len), 8'h00);
        send_cmd(2'd0, 8'd1);
        chk("l_ok_noerr", 8'(err_len), 8'h00);
        flit_step("l_wait", 8'h00);
        flit_step("l_head", 8'hBC);
        flit_step("l_d0", 8'h66);
        flit_step("l_trail", 8'hFF);
        step();

        // Async reset mid-BODY
        push(8'h01);
        push(8'h02);
        push(8'h03);
        send_cmd(2'd2, 8'd3);
        flit_step("r_wait", 8'h00);
        flit_step("r_head", 8'hBE);
        flit_step("r_d0", 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("r_flit", flit_out, 8'h00);
        chk("r_busy", 8'(busy), 8'h00);
        chk("r_full", 8'(full), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step();
        push(8'h44);
        send_cmd(2'd1, 8'd1);
        flit_step("r2_wait", 8'h00);
        flit_step("r2_head", 8'hBD);
        flit_step("r2_d0", 8'h44);
        flit_step("r2_trail", 8'hFF);
        step();

        // FIFO limits: 16 entries, 17th push dropped
        for (int i = 0; i < 16; i++) begin
            push(8'(16 + i));
            if (i == 14) chk("f_not_full", 8'(full), 8'h00);
        end
        chk("f_full", 8'(full), 8'h01);
        push(8'hAA);
        chk("f_full_drop", 8'(full), 8'h01);
        send_cmd(2'd0, 8'd15);
        flit_step("f_wait", 8'h00);
        flit_step("f_head", 8'hBC);
        for (int i = 0; i < 15; i++) begin
            flit_step("f_body", 8'(16 + i));
        end
        flit_step("f_trail", 8'hFF);
        chk("f_drained", 8'(full), 8'h00);
        step();
        send_cmd(2'd0, 8'd1);
        flit_step("f2_wait", 8'h00);
        flit_step("f2_head", 8'hBC);
        flit_step("f2_last", 8'h1F);
        flit_step("f2_trail", 8'hFF);
        step();
        step();
        chk("f2_busy", 8'(busy), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
